// File: rtl/bp_be_pkg.sv
// Shared backend types for the FMA/IMUL writeback buffer.
//   bp_be_fp_wb_pkt_s  : FP result as queued {rd, fflags, data}
//   bp_be_int_wb_pkt_s : integer result as queued {rd, data}
package bp_be_pkg;

  localparam int unsigned reg_addr_width_gp = 5;
  localparam int unsigned dword_width_gp    = 64;
  localparam int unsigned fp_reg_width_gp   = 66;
  localparam int unsigned fflags_width_gp   = 5;

  typedef logic [fflags_width_gp-1:0] bp_be_fflags_t;

  typedef struct packed {
    logic [reg_addr_width_gp-1:0] rd;
    bp_be_fflags_t                fflags;
    logic [fp_reg_width_gp-1:0]   data;
  } bp_be_fp_wb_pkt_s;

  typedef struct packed {
    logic [reg_addr_width_gp-1:0] rd;
    logic [dword_width_gp-1:0]    data;
  } bp_be_int_wb_pkt_s;

endpackage

// File: rtl/bp_be_wb_credit_fifo.sv
// Credit-reserved result FIFO behind a fixed-latency, non-stallable pipe.
// A shadow shift register tracks which issued ops are still live in the
// pipe; squashed results are dropped when they emerge.
//   clk_i, reset_n_i   : clock, async active-low reset
//   issue_i, flush_i   : reserve a credit / squash everything in the pipe
//   v_i, data_i        : result arriving from the pipe
//   credit_o           : free entries (els - occupancy - inflight), registered
//   v_o, ready_i, data_o : head of queue, valid/ready drain
module bp_be_wb_credit_fifo #(
  parameter int unsigned width_p   = 8,
  parameter int unsigned els_p     = 4,
  parameter int unsigned latency_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       issue_i,
  input  logic                       flush_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic [$clog2(els_p+1)-1:0] credit_o,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic [width_p-1:0]         data_o
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  localparam int unsigned cnt_w_lp = $clog2(els_p+1);

  logic [width_p-1:0]   mem_r [els_p];
  logic [ptr_w_lp-1:0]  wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0]  count_r, count_n, credit_r, credit_n;
  logic [latency_p-1:0] shadow_r, shadow_n;
  logic                 exit_bit, issue_eff, push, pop;

  assign exit_bit  = shadow_r[latency_p-1];
  assign issue_eff = issue_i & ~flush_i;
  assign push      = v_i & exit_bit;
  assign v_o       = (count_r != '0);
  assign pop       = v_o & ready_i;
  assign data_o    = mem_r[rd_ptr_r];
  assign credit_o  = credit_r;

  // Shadow advance; flush wipes every op still inside the pipe.
  if (latency_p == 1) begin : g_shadow1
    always_comb begin
      shadow_n = '0;
      if (!flush_i) shadow_n = issue_eff;
    end
  end else begin : g_shadown
    always_comb begin
      shadow_n = '0;
      if (!flush_i) shadow_n = {shadow_r[latency_p-2:0], issue_eff};
    end
  end

  // Credit recomputed from next-state occupancy and inflight count.
  always_comb begin
    count_n  = count_r + cnt_w_lp'(push) - cnt_w_lp'(pop);
    credit_n = cnt_w_lp'(els_p) - count_n - cnt_w_lp'($countones(shadow_n));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      shadow_r <= '0;
      credit_r <= cnt_w_lp'(els_p);
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
      count_r  <= count_n;
      shadow_r <= shadow_n;
      credit_r <= credit_n;
    end
  end

  // Storage needs no reset; validity comes from count_r.
  always_ff @(posedge clk_i) begin
    if (push) mem_r[wr_ptr_r] <= data_i;
  end

  a_no_issue_without_credit: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(issue_eff && (credit_r == '0)));
  a_live_op_has_result: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(exit_bit && !v_i));
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(push && (count_r == cnt_w_lp'(els_p))));

endmodule

// File: rtl/bp_be_fma_wb_buffer.sv
// Writeback buffer for the FMA/IMUL pipe: one credit FIFO for integer
// results, one for FP results, plus sticky accumulation of popped FP fflags.
//   clk_i, reset_n_i                    : clock, async active-low reset
//   issue_fma_i, issue_imul_i, flush_i  : dispatch / squash controls
//   fma_*_i, imul_*_i                   : pipe results
//   fp_credit_o, int_credit_o           : free credits per queue
//   fp_wb_*, int_wb_*                   : valid/ready writeback ports
//   fflags_o, fflags_clear_i            : sticky FP flags and their clear
module bp_be_fma_wb_buffer
  import bp_be_pkg::*;
#(
  parameter int unsigned els_p            = 4,
  parameter int unsigned fma_latency_p    = 4,
  parameter int unsigned imul_latency_p   = 4,
  parameter int unsigned reg_addr_width_p = reg_addr_width_gp,
  parameter int unsigned dword_width_p    = dword_width_gp,
  parameter int unsigned fp_reg_width_p   = fp_reg_width_gp
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        issue_fma_i,
  input  logic                        issue_imul_i,
  input  logic                        flush_i,
  input  logic                        fma_v_i,
  input  logic [fp_reg_width_p-1:0]   fma_data_i,
  input  logic [4:0]                  fma_fflags_i,
  input  logic [reg_addr_width_p-1:0] fma_rd_i,
  input  logic                        imul_v_i,
  input  logic [dword_width_p-1:0]    imul_data_i,
  input  logic [reg_addr_width_p-1:0] imul_rd_i,
  output logic [$clog2(els_p+1)-1:0]  fp_credit_o,
  output logic [$clog2(els_p+1)-1:0]  int_credit_o,
  output logic                        fp_wb_v_o,
  input  logic                        fp_wb_ready_i,
  output logic [fp_reg_width_p-1:0]   fp_wb_data_o,
  output logic [reg_addr_width_p-1:0] fp_wb_rd_o,
  output logic                        int_wb_v_o,
  input  logic                        int_wb_ready_i,
  output logic [dword_width_p-1:0]    int_wb_data_o,
  output logic [reg_addr_width_p-1:0] int_wb_rd_o,
  output logic [4:0]                  fflags_o,
  input  logic                        fflags_clear_i
);

  localparam int unsigned fp_pkt_w_lp  = $bits(bp_be_fp_wb_pkt_s);
  localparam int unsigned int_pkt_w_lp = $bits(bp_be_int_wb_pkt_s);

  bp_be_fp_wb_pkt_s  fp_in, fp_head;
  bp_be_int_wb_pkt_s int_in, int_head;
  bp_be_fflags_t     fflags_r, fflags_n;
  logic              fp_pop;

  assign fp_in  = '{rd: fma_rd_i, fflags: fma_fflags_i, data: fma_data_i};
  assign int_in = '{rd: imul_rd_i, data: imul_data_i};

  bp_be_wb_credit_fifo #(
    .width_p   (fp_pkt_w_lp),
    .els_p     (els_p),
    .latency_p (fma_latency_p)
  ) fp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .issue_i   (issue_fma_i),
    .flush_i   (flush_i),
    .v_i       (fma_v_i),
    .data_i    (fp_in),
    .credit_o  (fp_credit_o),
    .v_o       (fp_wb_v_o),
    .ready_i   (fp_wb_ready_i),
    .data_o    (fp_head)
  );

  bp_be_wb_credit_fifo #(
    .width_p   (int_pkt_w_lp),
    .els_p     (els_p),
    .latency_p (imul_latency_p)
  ) int_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .issue_i   (issue_imul_i),
    .flush_i   (flush_i),
    .v_i       (imul_v_i),
    .data_i    (int_in),
    .credit_o  (int_credit_o),
    .v_o       (int_wb_v_o),
    .ready_i   (int_wb_ready_i),
    .data_o    (int_head)
  );

  assign fp_wb_data_o  = fp_head.data;
  assign fp_wb_rd_o    = fp_head.rd;
  assign int_wb_data_o = int_head.data;
  assign int_wb_rd_o   = int_head.rd;
  assign fp_pop        = fp_wb_v_o & fp_wb_ready_i;

  // Clear takes effect before the popped entry's flags are OR-ed in.
  always_comb begin
    fflags_n = fflags_r;
    if (fflags_clear_i) fflags_n = '0;
    if (fp_pop)         fflags_n = fflags_n | fp_head.fflags;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) fflags_r <= '0;
    else            fflags_r <= fflags_n;
  end

  assign fflags_o = fflags_r;

endmodule
